// File: rtl/crop_window.sv
// crop_window: pass a CROP_W x CROP_H window of the pixel stream, starting at (XSTART, latched start row); optional CROP_CLAMP_EN clamps the start row
module crop_window #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int XSTART     = 160,
  parameter int CROP_W     = 320,
  parameter int CROP_H     = 120,
  parameter int DEF_YSTART = 0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [9:0]  iDATA,
  input  logic [15:0] iYSTART,
  output logic        oDVAL,
  output logic [9:0]  oDATA,
  output logic        oSOF,
  output logic        oEOL,
  output logic [15:0] oYUSED
);
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] X_LO   = 16'(XSTART);
  localparam logic [15:0] X_HI   = 16'(XSTART + CROP_W - 1);
  localparam logic [15:0] V_LIM  = 16'(V_ACTIVE);
  localparam logic [15:0] Y_MAX  = 16'(V_ACTIVE - CROP_H);
  localparam logic [15:0] Y_DEF  = 16'(DEF_YSTART);
  localparam logic [16:0] H_M1   = 17'(CROP_H - 1);

  typedef enum logic [1:0] {S_SKIP, S_CROP, S_DONE} state_t;

  state_t      state;
  logic [15:0] x, y, next_y;
  logic        line_end, frame_end, at_top, last_row, in_x, cropping, emit;

  // Position decode and window membership of the pixel currently on the input
  always_comb begin
    line_end  = x == H_LAST;
    frame_end = line_end && y == V_LAST;
    at_top    = y == oYUSED;
    last_row  = {1'b0, y} == {1'b0, oYUSED} + H_M1;
    in_x      = x >= X_LO && x <= X_HI;
    cropping  = state == S_CROP || (state == S_SKIP && at_top);
    emit      = cropping && in_x;
`ifdef CROP_CLAMP_EN
    next_y    = iYSTART > Y_MAX ? Y_MAX : iYSTART;
`else
    next_y    = iYSTART >= V_LIM ? oYUSED : iYSTART;
`endif
  end

  // Counters, window FSM and registered outputs, all advancing only on valid pixels
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state  <= S_SKIP;
      x      <= '0;
      y      <= '0;
      oDVAL  <= 1'b0;
      oSOF   <= 1'b0;
      oEOL   <= 1'b0;
      oDATA  <= '0;
      oYUSED <= Y_DEF;
    end else begin
      oDVAL <= iDVAL && emit;
      oSOF  <= iDVAL && emit && x == X_LO && at_top;
      oEOL  <= iDVAL && emit && x == X_HI;
      if (iDVAL) begin
        if (emit) oDATA <= iDATA;
        x <= line_end ? '0 : x + 16'd1;
        if (line_end) y <= frame_end ? '0 : y + 16'd1;
        if (frame_end) begin
          state  <= S_SKIP;
          oYUSED <= next_y;
        end else if (cropping) begin
          state <= (line_end && last_row) ? S_DONE : S_CROP;
        end
      end
    end
  end
endmodule

// File: tb/tb_crop_window.sv
// tb_crop_window: directed frames against a window-rule model of crop_window (honours CROP_CLAMP_EN)
module tb_crop_window;
  localparam int H  = 40;
  localparam int V  = 30;
  localparam int XS = 10;
  localparam int W  = 20;
  localparam int CH = 8;
  localparam int DEF = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dval = 1'b0;
  logic [9:0]  data = '0;
  logic [15:0] ystart = '0;
  logic        o_dval, o_sof, o_eol;
  logic [9:0]  o_data;
  logic [15:0] o_yused;

  int n_chk = 0;
  int n_err = 0;

  int bx = 0, by = 0, m_y = DEF;
  bit nxt_dval = 0, nxt_sof = 0, nxt_eol = 0;
  int nxt_data = 0, nxt_y = DEF;
  bit cur_dval, cur_sof, cur_eol;
  int cur_data, cur_y;

  int dval_cnt = 0, eol_cnt = 0, sof_cnt = 0, sof_data = -1, last_eol = -1;

  crop_window #(.H_ACTIVE(H), .V_ACTIVE(V), .XSTART(XS), .CROP_W(W), .CROP_H(CH), .DEF_YSTART(DEF)) dut (
    .iCLK(clk), .iRST(rst_n), .iDVAL(dval), .iDATA(data), .iYSTART(ystart),
    .oDVAL(o_dval), .oDATA(o_data), .oSOF(o_sof), .oEOL(o_eol), .oYUSED(o_yused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int latch_rule(input int ys, input int old);
`ifdef CROP_CLAMP_EN
    return ys > V - CH ? V - CH : ys;
`else
    return ys >= V ? old : ys;
`endif
  endfunction

  // Model expectations move to "current" on the same edge the DUT registers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dval <= 0; cur_sof <= 0; cur_eol <= 0; cur_data <= 0; cur_y <= DEF;
    end else begin
      cur_dval <= nxt_dval; cur_sof <= nxt_sof; cur_eol <= nxt_eol;
      cur_data <= nxt_data; cur_y <= nxt_y;
    end
  end

  // Compare process: every cycle, plus event statistics for the literal checks
  always @(negedge clk) begin
    chk("oDVAL", int'(o_dval), int'(cur_dval));
    chk("oSOF", int'(o_sof), int'(cur_sof));
    chk("oEOL", int'(o_eol), int'(cur_eol));
    chk("oDATA", int'(o_data), cur_data);
    chk("oYUSED", int'(o_yused), cur_y);
    if (o_dval) dval_cnt++;
    if (o_dval && o_eol) begin eol_cnt++; last_eol = int'(o_data); end
    if (o_dval && o_sof) begin sof_cnt++; sof_data = int'(o_data); end
  end

  task automatic model_reset();
    bx = 0; by = 0; m_y = DEF;
    nxt_dval = 0; nxt_sof = 0; nxt_eol = 0; nxt_data = 0; nxt_y = DEF;
  endtask

  task automatic drive(input bit dv, input int ys);
    bit win;
    dval = dv;
    ystart = 16'(ys);
    data = dv ? 10'((by % 32) * 32 + (bx % 32)) : 10'($urandom);
    if (dv) begin
      win = by >= m_y && by < m_y + CH && bx >= XS && bx < XS + W;
      nxt_dval = win;
      nxt_sof = win && bx == XS && by == m_y;
      nxt_eol = win && bx == XS + W - 1;
      if (win) nxt_data = int'(data);
      if (bx == H - 1 && by == V - 1) m_y = latch_rule(ys, m_y);
      nxt_y = m_y;
      bx = bx + 1;
      if (bx == H) begin bx = 0; by = (by + 1) % V; end
    end else begin
      nxt_dval = 0; nxt_sof = 0; nxt_eol = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int ys, input bit gaps);
    int n = 0;
    bit dv;
    while (n < H * V) begin
      dv = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      drive(dv, ys);
      if (dv) n++;
    end
    drive(0, ys);
  endtask

  task automatic frame(input string name, input int ys, input bit gaps, input int e_dval,
                       input int e_eol, input int e_sof, input int e_last, input int e_y);
    int d0, e0, s0;
    d0 = dval_cnt; e0 = eol_cnt; s0 = sof_cnt;
    run_frame(ys, gaps);
    chk({name, " dval count"}, dval_cnt - d0, e_dval);
    chk({name, " eol count"}, eol_cnt - e0, e_eol);
    chk({name, " sof count"}, sof_cnt - s0, 1);
    chk({name, " sof data"}, sof_data, e_sof);
    chk({name, " last eol data"}, last_eol, e_last);
    chk({name, " yused after"}, int'(o_yused), e_y);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset oDVAL", int'(o_dval), 0);
    chk("reset oDATA", int'(o_data), 0);
    chk("reset oYUSED", int'(o_yused), DEF);
    rst_n = 1'b1;
    frame("A default window", 5, 0, CH * W, CH, 10, 7 * 32 + 29, 5);
    frame("B row 5", 22, 0, CH * W, CH, 5 * 32 + 10, 12 * 32 + 29,
`ifdef CROP_CLAMP_EN
          22);
`else
          22);
`endif
`ifdef CROP_CLAMP_EN
    frame("C bottom fit", 27, 0, CH * W, CH, 22 * 32 + 10, 29 * 32 + 29, 22);
    frame("D clamped", 40, 0, CH * W, CH, 22 * 32 + 10, 29 * 32 + 29, 22);
    frame("E gaps", 3, 1, CH * W, CH, 22 * 32 + 10, 29 * 32 + 29, 3);
`else
    frame("C bottom fit", 27, 0, CH * W, CH, 22 * 32 + 10, 29 * 32 + 29, 27);
    frame("D overrun", 40, 0, 3 * W, 3, 27 * 32 + 10, 29 * 32 + 29, 27);
    frame("E gaps", 3, 1, 3 * W, 3, 27 * 32 + 10, 29 * 32 + 29, 3);
`endif
    while (!(by == 7 && bx == 15)) drive(1, 9);
    chk("pre-reset oDVAL", int'(o_dval), 1);
    rst_n = 1'b0;
    model_reset();
    dval = 1'b0;
    #1;
    chk("mid reset oDVAL", int'(o_dval), 0);
    chk("mid reset oDATA", int'(o_data), 0);
    chk("mid reset oYUSED", int'(o_yused), DEF);
    chk("mid reset oEOL", int'(o_eol), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame("G after reset", 0, 0, CH * W, CH, 10, 7 * 32 + 29, 0);
    repeat (3) drive(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
